// File: rtl/pipelined_data_selector.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_data_selector
//  Description : Registered lane crossbar. Each output lane picks one word
//                from either the main bus or the register-file bus according
//                to a double-buffered (shadow/active) select configuration
//                that is only swapped in while the datapath is not stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_data_selector #(
    parameter int DATA_WIDTH      = 4,
    parameter int MAIN_INPUTS     = 16,
    parameter int REGS_INPUTS     = 64,
    parameter int OUTPUTS         = 4,
    parameter int OUTPUTS_PER_BUS = 4,
    localparam int LANES = OUTPUTS * OUTPUTS_PER_BUS,
    localparam int MW    = $clog2(MAIN_INPUTS),
    localparam int RW    = $clog2(REGS_INPUTS),
    localparam int FW    = 1 + MW + RW
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wBusy,
    input  logic                              cfg_load,
    input  logic [LANES*FW-1:0]               wSelec,
    input  logic                              in_valid,
    input  logic [MAIN_INPUTS*DATA_WIDTH-1:0] wData,
    input  logic [REGS_INPUTS*DATA_WIDTH-1:0] wRegs,
    output logic [LANES*DATA_WIDTH-1:0]       r,
    output logic                              out_valid,
    output logic                              cfg_ack,
    output logic                              sel_err
);

    typedef enum logic [1:0] {
        UNCFG   = 2'd0,
        ACTIVE  = 2'd1,
        PENDING = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_nextState;
    logic [LANES*FW-1:0]         r_shadowCfg;
    logic [LANES*FW-1:0]         r_activeCfg;
    logic                        r_pending;
    logic                        w_apply;
    logic [LANES*FW-1:0]         w_applyCfg;
    logic [LANES-1:0]            w_laneErr;
    logic [LANES*DATA_WIDTH-1:0] w_selected;
    logic                        w_sample;

    // Word tables padded to a power of two; padding entries read as zero so
    // an out-of-range index naturally yields a zero lane.
    logic [DATA_WIDTH-1:0] w_mainWords [2**MW];
    logic [DATA_WIDTH-1:0] w_regsWords [2**RW];

    generate
        for (genvar k = 0; k < 2**MW; k++) begin : g_mainWords
            if (k < MAIN_INPUTS) begin : g_real
                assign w_mainWords[k] = wData[k*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_pad
                assign w_mainWords[k] = '0;
            end
        end

        for (genvar k = 0; k < 2**RW; k++) begin : g_regsWords
            if (k < REGS_INPUTS) begin : g_real
                assign w_regsWords[k] = wRegs[k*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_pad
                assign w_regsWords[k] = '0;
            end
        end

        // Per lane: select from the active configuration, and check the
        // configuration about to be applied for out-of-range indices.
        for (genvar i = 0; i < LANES; i++) begin : g_lanes
            logic [MW-1:0] w_actMain;
            logic [RW-1:0] w_actRegs;
            logic [MW-1:0] w_newMain;
            logic [RW-1:0] w_newRegs;

            assign w_actMain = r_activeCfg[i*FW+1 +: MW];
            assign w_actRegs = r_activeCfg[i*FW+1+MW +: RW];
            assign w_newMain = w_applyCfg[i*FW+1 +: MW];
            assign w_newRegs = w_applyCfg[i*FW+1+MW +: RW];

            assign w_selected[i*DATA_WIDTH +: DATA_WIDTH] =
                r_activeCfg[i*FW] ? w_regsWords[w_actRegs] : w_mainWords[w_actMain];

            assign w_laneErr[i] = w_applyCfg[i*FW]
                ? (32'(w_newRegs) >= 32'(REGS_INPUTS))
                : (32'(w_newMain) >= 32'(MAIN_INPUTS));
        end
    endgenerate

    // Sampling is only meaningful once some configuration has been loaded.
    assign w_sample = (r_state != UNCFG) && in_valid && !wBusy;

    // Next state: a load applies immediately unless stalled; a stalled load
    // waits in PENDING and applies (newest shadow) on the first idle cycle.
    always_comb begin
        w_nextState = r_state;
        w_apply     = 1'b0;
        w_applyCfg  = r_shadowCfg;
        if (cfg_load) begin
            w_applyCfg = wSelec;
            if (!wBusy) begin
                w_apply     = 1'b1;
                w_nextState = ACTIVE;
            end else begin
                w_nextState = PENDING;
            end
        end else if (r_pending && !wBusy) begin
            w_apply     = 1'b1;
            w_nextState = ACTIVE;
        end
    end

    // Configuration registers: state, shadow, active, pending, ack and error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= UNCFG;
            r_shadowCfg <= '0;
            r_activeCfg <= '0;
            r_pending   <= 1'b0;
            cfg_ack     <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_pending <= (w_nextState == PENDING);
            cfg_ack   <= w_apply;
            if (cfg_load) begin
                r_shadowCfg <= wSelec;
            end
            if (w_apply) begin
                r_activeCfg <= w_applyCfg;
                sel_err     <= |w_laneErr;
            end
        end
    end

    // Output stage: samples with the configuration active before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r         <= '0;
            out_valid <= 1'b0;
        end else if (!wBusy) begin
            if (w_sample) begin
                r         <= w_selected;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_data_selector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_data_selector
//  Description : Scoreboard bench for pipelined_data_selector with directed
//                vectors; a second instance uses 12 main inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_data_selector;

    localparam int SELW = 176;

    logic         clk = 1'b0;
    logic         rst;
    logic         wBusy;
    logic         cfg_load;
    logic [SELW-1:0] wSelec;
    logic         in_valid;
    logic [63:0]  wData;
    logic [255:0] wRegs;
    logic [63:0]  r;
    logic         out_valid;
    logic         cfg_ack;
    logic         sel_err;

    logic         busy12;
    logic         cfgLoad12;
    logic [SELW-1:0] selec12;
    logic         inValid12;
    logic [47:0]  data12;
    logic [255:0] regs12;
    logic [63:0]  r12;
    logic         outValid12;
    logic         cfgAck12;
    logic         selErr12;

    int errors = 0;
    int checks = 0;
    logic [63:0] expQ[$];
    logic        busyAtEdge = 1'b0;

    always #5 clk = ~clk;

    pipelined_data_selector dut (
        .clk(clk), .rst(rst), .wBusy(wBusy), .cfg_load(cfg_load),
        .wSelec(wSelec), .in_valid(in_valid), .wData(wData), .wRegs(wRegs),
        .r(r), .out_valid(out_valid), .cfg_ack(cfg_ack), .sel_err(sel_err)
    );

    pipelined_data_selector #(.MAIN_INPUTS(12)) dut12 (
        .clk(clk), .rst(rst), .wBusy(busy12), .cfg_load(cfgLoad12),
        .wSelec(selec12), .in_valid(inValid12), .wData(data12), .wRegs(regs12),
        .r(r12), .out_valid(outValid12), .cfg_ack(cfgAck12), .sel_err(selErr12)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] fld(input logic origin, input int idx);
        logic [10:0] f;
        if (origin) f = {6'(idx), 4'd0, 1'b1};
        else        f = {6'd0, 4'(idx), 1'b0};
        return f;
    endfunction

    function automatic logic [SELW-1:0] mkCfg(input logic [10:0] def, input logic [10:0] l0,
                                              input logic [10:0] l2, input logic [10:0] l15);
        logic [SELW-1:0] c;
        for (int i = 0; i < 16; i++) c[i*11 +: 11] = def;
        c[0*11 +: 11]  = l0;
        c[2*11 +: 11]  = l2;
        c[15*11 +: 11] = l15;
        return c;
    endfunction

    task automatic setD1();
        wData = '0; wRegs = '0;
        wData[0*4 +: 4]  = 4'h1;
        wData[3*4 +: 4]  = 4'hA;
        wRegs[63*4 +: 4] = 4'h5;
    endtask

    task automatic setD2();
        setD1();
        wData[1*4 +: 4] = 4'h3;
        wData[5*4 +: 4] = 4'hC;
        wRegs[2*4 +: 4] = 4'h7;
    endtask

    // Track whether the most recent edge was a stall, so held outputs are not re-scored.
    always @(posedge clk) busyAtEdge <= wBusy;

    // Monitor: every fresh output sample is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (out_valid && !busyAtEdge) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: unexpected output %h", r);
            end else begin
                check("scoreboard r", r, expQ.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [SELW-1:0] cfgA, cfgB, cfgBad;
        logic [63:0] expA, expB;
        cfgA   = mkCfg(fld(0, 0), fld(0, 3), fld(0, 0), fld(1, 63));
        cfgB   = mkCfg(fld(0, 1), fld(1, 2), fld(0, 1), fld(0, 5));
        cfgBad = mkCfg(fld(0, 0), fld(0, 0), fld(0, 13), fld(0, 0));
        expA   = 64'h5111_1111_1111_111A;
        expB   = 64'hC333_3333_3333_3337;

        rst = 1'b1; wBusy = 1'b0; cfg_load = 1'b0; wSelec = '0; in_valid = 1'b0;
        wData = '0; wRegs = '0;
        busy12 = 1'b0; cfgLoad12 = 1'b0; selec12 = '0; inValid12 = 1'b0;
        data12 = '0; regs12 = '0;
        tick(); tick();
        rst = 1'b0;
        check("reset out_valid", out_valid, 0);
        check("reset r", r, 0);
        check("reset cfg_ack", cfg_ack, 0);
        check("reset sel_err", sel_err, 0);

        // Unconfigured: samples are ignored.
        setD1(); in_valid = 1'b1;
        tick(); tick();
        check("uncfg out_valid", out_valid, 0);
        check("uncfg r", r, 0);
        in_valid = 1'b0;

        // Basic configuration and sample.
        cfg_load = 1'b1; wSelec = cfgA;
        tick();
        cfg_load = 1'b0;
        check("cfgA ack", cfg_ack, 1);
        tick();
        check("cfgA ack one cycle", cfg_ack, 0);
        in_valid = 1'b1; expQ.push_back(expA);
        tick();
        in_valid = 1'b0;
        tick();
        check("idle clears out_valid", out_valid, 0);

        // Boundary: load B together with a sample -> sample uses A, next uses B.
        setD2();
        cfg_load = 1'b1; wSelec = cfgB; in_valid = 1'b1; expQ.push_back(expA);
        tick();
        cfg_load = 1'b0; expQ.push_back(expB);
        check("boundary ack", cfg_ack, 1);
        tick();
        check("boundary ack drop", cfg_ack, 0);
        in_valid = 1'b0;
        tick();

        // Load under stall for three cycles with in_valid pulses.
        setD1();
        wBusy = 1'b1; cfg_load = 1'b1; wSelec = cfgA;
        for (int i = 0; i < 3; i++) begin
            in_valid = (i != 1);
            tick();
            check("stall no ack", cfg_ack, 0);
            check("stall r held", r, expB);
            check("stall out_valid held", out_valid, 0);
        end
        cfg_load = 1'b0; wBusy = 1'b0; in_valid = 1'b0;
        tick();
        check("pending ack after stall", cfg_ack, 1);
        tick();
        check("pending ack drop", cfg_ack, 0);
        in_valid = 1'b1; expQ.push_back(expA);
        tick();
        in_valid = 1'b0; wBusy = 1'b1;
        tick();
        check("stall holds out_valid", out_valid, 1);
        tick();
        check("stall holds out_valid 2", out_valid, 1);
        wBusy = 1'b0;
        tick();
        check("release clears out_valid", out_valid, 0);

        // Reset while PENDING discards the pending load.
        wBusy = 1'b1; cfg_load = 1'b1; wSelec = cfgB;
        tick();
        check("pending entry no ack", cfg_ack, 0);
        cfg_load = 1'b0; wBusy = 1'b0; rst = 1'b1; in_valid = 1'b1;
        tick();
        rst = 1'b0;
        check("reset in pending ack", cfg_ack, 0);
        check("reset in pending r", r, 0);
        check("reset in pending out_valid", out_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post reset no ack", cfg_ack, 0);
            check("post reset uncfg", out_valid, 0);
        end
        in_valid = 1'b0;

        // Out-of-range index with 12 main inputs.
        data12 = '0; data12[0*4 +: 4] = 4'h9;
        cfgLoad12 = 1'b1; selec12 = cfgBad;
        tick();
        cfgLoad12 = 1'b0;
        check("bad cfg ack", cfgAck12, 1);
        check("bad cfg sel_err", selErr12, 1);
        inValid12 = 1'b1;
        tick();
        inValid12 = 1'b0;
        check("bad lane zero", r12, 64'h9999_9999_9999_9099);
        check("bad out_valid", outValid12, 1);
        tick();
        check("sel_err sticky", selErr12, 1);
        cfgLoad12 = 1'b1; selec12 = '0;
        tick();
        cfgLoad12 = 1'b0;
        check("good cfg clears sel_err", selErr12, 0);

        tick(); tick();
        check("scoreboard drained", 64'(expQ.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
